// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Two-port round-robin arbiter in front of one asynchronous 8-bit SRAM.
// Port A sees a 64 KB window at {A_BASE, addr_a}; port B addresses the
// whole 2 MB space. Each transfer walks IDLE -> SETUP -> ACCESS -> HOLD,
// so latency is fixed: ack rises after edge E0+2+WAIT_CYCLES, where E0 is
// the granting IDLE edge.
//
// Parameters
//   WAIT_CYCLES  extra ACCESS cycles per transfer (0..15)
//   A_BASE       SRAM_ADDR[20:16] used for port A transfers
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   req_x/we_x/addr_x/din_x  request, write flag, address, write data
//                         (x = a | b); held stable until ack_x
//   ack_x                 one-cycle completion pulse
//   dout_x                read data, updated only when a read on that port
//                         completes
//   busy                  high whenever the FSM is not IDLE
//   SRAM_ADDR             registered SRAM address
//   SRAM_DATA             SRAM data bus, driven only during writes
//   SRAM_WE_n             registered active-low write strobe
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [4:0]  A_BASE      = 5'b00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic        we_a,
  input  logic [15:0] addr_a,
  input  logic [7:0]  din_a,
  output logic        ack_a,
  output logic [7:0]  dout_a,
  input  logic        req_b,
  input  logic        we_b,
  input  logic [20:0] addr_b,
  input  logic [7:0]  din_b,
  output logic        ack_b,
  output logic [7:0]  dout_b,
  output logic        busy,
  output logic [20:0] SRAM_ADDR,
  inout  wire  [7:0]  SRAM_DATA,
  output logic        SRAM_WE_n
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t      state, state_d;
  logic        last_b;     // 1: port B was granted most recently
  logic        grant_b;    // port owning the transfer in progress
  logic        we_q;
  logic [7:0]  din_q;
  logic        drive_en;
  logic [3:0]  cnt;

  // FSM strobes decoded from the current state
  logic        start;      // grant at this edge
  logic        arm;        // SETUP: assert strobe, load wait counter
  logic        wait_tick;  // ACCESS with cycles still to wait
  logic        done;       // ACCESS finished: complete the transfer
  logic        release_q;  // HOLD: drop ack and the bus driver

  // On a tie, B wins only if A was served last; a lone requester always wins.
  logic        pick_b;
  assign pick_b = req_b && (!req_a || !last_b);

  assign busy      = (state != IDLE);
  assign SRAM_DATA = drive_en ? din_q : 8'bz;

  // NOTE: every output of a combinational block gets a default before the
  // case statement, otherwise an unassigned path infers a latch.
  always_comb begin
    state_d   = state;
    start     = 1'b0;
    arm       = 1'b0;
    wait_tick = 1'b0;
    done      = 1'b0;
    release_q = 1'b0;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          start   = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        arm     = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt != 4'd0) begin
          wait_tick = 1'b1;
        end else begin
          done    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        release_q = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Reset here also aborts a transfer in flight: the strobe rises and the
  // bus is released the moment reset is asserted, not at the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_b    <= 1'b1;
      grant_b   <= 1'b0;
      we_q      <= 1'b0;
      din_q     <= 8'h00;
      drive_en  <= 1'b0;
      cnt       <= 4'd0;
      SRAM_ADDR <= 21'h0;
      SRAM_WE_n <= 1'b1;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      dout_a    <= 8'h00;
      dout_b    <= 8'h00;
    end else begin
      if (start) begin
        grant_b   <= pick_b;
        last_b    <= pick_b;
        we_q      <= pick_b ? we_b : we_a;
        din_q     <= pick_b ? din_b : din_a;
        drive_en  <= pick_b ? we_b : we_a;
        SRAM_ADDR <= pick_b ? addr_b : {A_BASE, addr_a};
      end
      if (arm) begin
        SRAM_WE_n <= ~we_q;
        cnt       <= 4'(WAIT_CYCLES);
      end
      if (wait_tick) begin
        cnt <= cnt - 4'd1;
      end
      if (done) begin
        SRAM_WE_n <= 1'b1;
        if (grant_b) begin
          ack_b <= 1'b1;
          if (!we_q) dout_b <= SRAM_DATA;
        end else begin
          ack_a <= 1'b1;
          if (!we_q) dout_a <= SRAM_DATA;
        end
      end
      // Data stays on the bus through HOLD, one cycle past the strobe rise.
      if (release_q) begin
        ack_a    <= 1'b0;
        ack_b    <= 1'b0;
        drive_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed bench for sram_arbiter. The main instance runs with
// WAIT_CYCLES=1; a second instance with WAIT_CYCLES=0 covers the minimum
// latency case. A tiny SRAM model remembers the last write (captured on the
// rising write strobe) and returns it for that address, 8'h3C elsewhere.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [15:0] addr_a = 16'h0;
  logic [20:0] addr_b = 21'h0;
  logic [7:0]  din_a = 8'h0, din_b = 8'h0;
  logic        ack_a, ack_b, busy, SRAM_WE_n;
  logic [7:0]  dout_a, dout_b;
  logic [20:0] SRAM_ADDR;
  wire  [7:0]  sram_data;

  // second instance, WAIT_CYCLES = 0, port B only
  logic        req_b0 = 1'b0;
  logic        ack_a0, ack_b0, busy0, we_n0;
  logic [7:0]  dout_a0, dout_b0;
  logic [20:0] addr0;
  wire  [7:0]  sram_data0;

  // SRAM model
  logic        model_oe = 1'b0;
  logic [20:0] wr_addr_q = 21'h1FFFFF;
  logic [7:0]  wr_data_q = 8'h00;
  logic [7:0]  model_dout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.WAIT_CYCLES(1), .A_BASE(5'b00000)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .ack_a(ack_a), .dout_a(dout_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .ack_b(ack_b), .dout_b(dout_b),
    .busy(busy), .SRAM_ADDR(SRAM_ADDR), .SRAM_DATA(sram_data),
    .SRAM_WE_n(SRAM_WE_n)
  );

  sram_arbiter #(.WAIT_CYCLES(0), .A_BASE(5'b00000)) dut0 (
    .clk(clk), .reset(reset),
    .req_a(1'b0), .we_a(1'b0), .addr_a(16'h0), .din_a(8'h0),
    .ack_a(ack_a0), .dout_a(dout_a0),
    .req_b(req_b0), .we_b(1'b0), .addr_b(21'h0ABCDE), .din_b(8'h0),
    .ack_b(ack_b0), .dout_b(dout_b0),
    .busy(busy0), .SRAM_ADDR(addr0), .SRAM_DATA(sram_data0),
    .SRAM_WE_n(we_n0)
  );

  assign model_dout = (SRAM_ADDR == wr_addr_q) ? wr_data_q : 8'h3C;
  assign sram_data  = model_oe ? model_dout : 8'bz;
  assign sram_data0 = 8'h77;

  always @(posedge SRAM_WE_n) begin
    if (!reset) begin
      wr_addr_q <= SRAM_ADDR;
      wr_data_q <= sram_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int we_low, drv, acks, ack_at, bad, both, n_ack, busy_cnt;
  int ack_edge[4];
  logic ack_port[4];

  initial begin
    // ---------------- reset state
    model_oe = 1'b1;
    step();
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_we_n",  32'(SRAM_WE_n), 32'd1);
    check("rst_addr",  32'(SRAM_ADDR), 32'h0);
    check("rst_acks",  32'({ack_a, ack_b}), 32'd0);
    check("rst_douts", 32'({dout_a, dout_b}), 32'h0);
    check("rst_bus_z", 32'(sram_data), 32'h3C);
    model_oe = 1'b0;
    reset = 1'b0;
    step();

    // ---------------- port A write
    req_a = 1'b1; we_a = 1'b1; addr_a = 16'h1234; din_a = 8'hA5;
    we_low = 0; drv = 0; acks = 0; ack_at = -1; bad = 0;
    for (int e = 0; e < 8; e++) begin
      step();
      if (e == 0) check("wr_sram_addr", 32'(SRAM_ADDR), 32'h001234);
      if (!SRAM_WE_n) we_low++;
      if (sram_data === 8'hA5) drv++;
      if (ack_b) bad++;
      if (ack_a) begin acks++; ack_at = e; req_a = 1'b0; end
    end
    check("wr_we_low_cycles", 32'(we_low), 32'd2);
    check("wr_drive_cycles",  32'(drv), 32'd4);
    check("wr_ack_count",     32'(acks), 32'd1);
    check("wr_ack_edge",      32'(ack_at), 32'd3);
    check("wr_no_ack_b",      32'(bad), 32'd0);
    check("wr_model_addr",    32'(wr_addr_q), 32'h001234);
    check("wr_model_data",    32'(wr_data_q), 32'hA5);

    // ---------------- port A read of the same location
    req_a = 1'b1; we_a = 1'b0; din_a = 8'h5A; model_oe = 1'b1;
    we_low = 0; bad = 0; acks = 0; ack_at = -1;
    for (int e = 0; e < 8; e++) begin
      step();
      if (!SRAM_WE_n) we_low++;
      if (e < 4 && sram_data !== 8'hA5) bad++;
      if (ack_a) begin
        acks++; ack_at = e; req_a = 1'b0;
        check("rd_dout_a", 32'(dout_a), 32'hA5);
      end
    end
    check("rd_we_stays_high", 32'(we_low), 32'd0);
    check("rd_bus_not_driven", 32'(bad), 32'd0);
    check("rd_ack_edge", 32'(ack_at), 32'd3);
    check("rd_ack_count", 32'(acks), 32'd1);

    // ---------------- port B read, high address
    req_b = 1'b1; we_b = 1'b0; addr_b = 21'h1F0000; din_b = 8'h00;
    acks = 0; bad = 0; ack_at = -1;
    for (int e = 0; e < 8; e++) begin
      step();
      if (e == 0) check("b_sram_addr", 32'(SRAM_ADDR), 32'h1F0000);
      if (ack_a) bad++;
      if (ack_b) begin acks++; ack_at = e; req_b = 1'b0; end
    end
    model_oe = 1'b0;
    check("b_ack_edge",  32'(ack_at), 32'd3);
    check("b_ack_count", 32'(acks), 32'd1);
    check("b_no_ack_a",  32'(bad), 32'd0);
    check("b_dout_b",    32'(dout_b), 32'h3C);
    check("b_dout_a_kept", 32'(dout_a), 32'hA5);

    // ---------------- round robin with both requests held from reset
    reset = 1'b1;
    req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0;
    step();
    reset = 1'b0;
    n_ack = 0; both = 0;
    for (int e = 0; e < 30; e++) begin
      step();
      if (ack_a && ack_b) both++;
      if ((ack_a || ack_b) && n_ack < 4) begin
        ack_edge[n_ack] = e;
        ack_port[n_ack] = ack_b;
        n_ack++;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    check("rr_ack_count", 32'(n_ack), 32'd4);
    check("rr_grant0_A", 32'(ack_port[0]), 32'd0);
    check("rr_grant1_B", 32'(ack_port[1]), 32'd1);
    check("rr_grant2_A", 32'(ack_port[2]), 32'd0);
    check("rr_grant3_B", 32'(ack_port[3]), 32'd1);
    check("rr_first_ack_edge", 32'(ack_edge[0]), 32'd3);
    for (int i = 1; i < 4; i++)
      check($sformatf("rr_spacing%0d", i), 32'(ack_edge[i] - ack_edge[i-1]), 32'd5);
    check("rr_acks_exclusive", 32'(both), 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("rr_idle_after", 32'(busy), 32'd0);

    // ---------------- reset in the middle of a write
    req_a = 1'b1; we_a = 1'b1; addr_a = 16'h0055; din_a = 8'hC3;
    step();   // E0: grant
    step();   // E1: SETUP -> ACCESS, strobe low
    check("mid_we_low", 32'(SRAM_WE_n), 32'd0);
    #2;
    reset = 1'b1; model_oe = 1'b1;
    #1;
    check("mid_we_async_high", 32'(SRAM_WE_n), 32'd1);
    check("mid_bus_released",  32'(sram_data), 32'h3C);
    check("mid_busy_cleared",  32'(busy), 32'd0);
    acks = 0;
    for (int e = 0; e < 2; e++) begin
      step();
      if (ack_a || ack_b) acks++;
    end
    check("mid_no_ack", 32'(acks), 32'd0);
    we_a = 1'b0; req_b = 1'b1; we_b = 1'b0; addr_b = 21'h0;
    reset = 1'b0;
    ack_at = -1; bad = 0;
    for (int e = 0; e < 10 && ack_at < 0; e++) begin
      step();
      if (ack_a || ack_b) begin ack_at = e; bad = 32'(ack_b); end
    end
    req_a = 1'b0; req_b = 1'b0; model_oe = 1'b0;
    check("post_rst_first_ack_edge", 32'(ack_at), 32'd3);
    check("post_rst_tie_grants_A", 32'(bad), 32'd0);
    for (int i = 0; i < 6; i++) step();

    // ---------------- WAIT_CYCLES = 0 instance
    req_b0 = 1'b1;
    busy_cnt = 0; ack_at = -1; bad = 0;
    for (int e = 0; e < 6; e++) begin
      step();
      if (busy0) busy_cnt++;
      if (ack_a0) bad++;
      if (ack_b0) begin ack_at = e; req_b0 = 1'b0; end
    end
    check("w0_ack_edge", 32'(ack_at), 32'd2);
    check("w0_busy_cycles", 32'(busy_cnt), 32'd3);
    check("w0_dout_b", 32'(dout_b0), 32'h77);
    check("w0_sram_addr", 32'(addr0), 32'h0ABCDE);
    check("w0_no_ack_a", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
